// File: rtl/uart_tx_fifo_feeder.sv
// Byte FIFO that feeds a downstream UART transmitter one frame at a time.
// A small FSM pops a byte, holds it on Senddat with TxEn high until Doneflg, then idles one gap cycle.
module uart_tx_fifo_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          WrEn,
  input  logic [7:0]    WrData,
  input  logic          Flush,
  input  logic          Doneflg,
  output logic          TxEn,
  output logic [7:0]    Senddat,
  output logic          Full,
  output logic          Empty,
  output logic [AW:0]   Count,
  output logic          Busy,
  output logic          Overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          txen_q, txen_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    senddat_q, senddat_d;
  logic [7:0]    mem_q [DEPTH];
  logic          pop;
  logic          wr_acc;

  always_comb begin
    state_d   = state_q;
    txen_d    = txen_q;
    senddat_d = senddat_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: if (!empty_q) state_d = LOAD;
      LOAD: begin
        // A flush on the way into LOAD can leave nothing to pop.
        if (!empty_q) begin
          pop       = 1'b1;
          senddat_d = mem_q[rd_ptr_q];
          txen_d    = 1'b1;
          state_d   = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (Doneflg) begin
          txen_d  = 1'b0;
          state_d = GAP;
        end
      end
      GAP:     state_d = empty_q ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_acc   = WrEn && !full_q && !Flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (Flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      wr_ptr_d = wr_ptr_q + AW'(wr_acc);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + (AW+1)'(wr_acc) - (AW+1)'(pop);
      ovf_d    = ovf_q | (WrEn & full_q);
    end
    full_d  = (count_d == (AW+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      txen_q    <= 1'b0;
      ovf_q     <= 1'b0;
      senddat_q <= 8'h00;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      txen_q    <= txen_d;
      ovf_q     <= ovf_d;
      senddat_q <= senddat_d;
    end
  end

  // Storage is not reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (wr_acc && !RST) mem_q[wr_ptr_q] <= WrData;
  end

  assign TxEn     = txen_q;
  assign Senddat  = senddat_q;
  assign Full     = full_q;
  assign Empty    = empty_q;
  assign Count    = count_q;
  assign Busy     = (state_q != IDLE);
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Directed bench for uart_tx_fifo_feeder with a queue-based reference model checked every cycle.
module tb_uart_tx_fifo_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          CLK = 1'b0;
  logic          RST, WrEn, Flush, Doneflg;
  logic [7:0]    WrData;
  logic          TxEn, Full, Empty, Busy, Overflow;
  logic [7:0]    Senddat;
  logic [AW:0]   Count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  uart_tx_fifo_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrData(WrData), .Flush(Flush),
    .Doneflg(Doneflg), .TxEn(TxEn), .Senddat(Senddat), .Full(Full),
    .Empty(Empty), .Count(Count), .Busy(Busy), .Overflow(Overflow)
  );

  always #5 CLK = ~CLK;

  // Reference model: queue of stored bytes plus the transmitter phase.
  logic [7:0] mq[$];
  int         m_st  = 0;   // 0 idle, 1 load, 2 send, 3 gap
  bit         m_tx  = 1'b0;
  logic [7:0] m_sd  = 8'h00;
  bit         m_ovf = 1'b0;

  always @(posedge CLK) begin : model
    bit was_empty, was_full, do_pop;
    if (RST) begin
      mq.delete(); m_st = 0; m_tx = 1'b0; m_sd = 8'h00; m_ovf = 1'b0;
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      do_pop    = 1'b0;
      case (m_st)
        0: if (!was_empty) m_st = 1;
        1: if (!was_empty) begin m_sd = mq[0]; do_pop = 1'b1; m_tx = 1'b1; m_st = 2; end
           else m_st = 0;
        2: if (Doneflg) begin m_tx = 1'b0; m_st = 3; end
        default: m_st = was_empty ? 0 : 1;
      endcase
      if (Flush) begin
        mq.delete(); m_ovf = 1'b0;
      end else begin
        if (do_pop) void'(mq.pop_front());
        if (WrEn) begin
          if (was_full) m_ovf = 1'b1;
          else mq.push_back(WrData);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      total++;
      if (TxEn !== m_tx || Senddat !== m_sd || Count !== (AW+1)'(mq.size()) ||
          Full !== (mq.size() == DEPTH) || Empty !== (mq.size() == 0) ||
          Busy !== (m_st != 0) || Overflow !== m_ovf) begin
        bad++;
        $display("FAIL cycle_model t=%0t got tx=%b sd=%h cnt=%0d full=%b empty=%b busy=%b ovf=%b exp tx=%b sd=%h cnt=%0d full=%b empty=%b busy=%b ovf=%b",
                 $time, TxEn, Senddat, Count, Full, Empty, Busy, Overflow,
                 m_tx, m_sd, mq.size(), (mq.size() == DEPTH), (mq.size() == 0), (m_st != 0), m_ovf);
      end
    end
  end

  // Record every byte the DUT starts transmitting.
  logic [7:0] sent[$];
  bit         tx_prev = 1'b0;
  always @(negedge CLK) begin
    if (TxEn === 1'b1 && !tx_prev) sent.push_back(Senddat);
    tx_prev = (TxEn === 1'b1);
  end

  task automatic cyc(input bit wr, input logic [7:0] d, input bit fl, input bit dn, input bit rs = 1'b0);
    WrEn = wr; WrData = d; Flush = fl; Doneflg = dn; RST = rs;
    @(negedge CLK);
    WrEn = 1'b0; Flush = 1'b0; Doneflg = 1'b0; RST = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_tx(input int lim);
    int n = 0;
    while (TxEn !== 1'b1 && n < lim) begin cyc(1'b0, 8'h00, 1'b0, 1'b0); n++; end
    if (TxEn !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_tx_timeout got=%b exp=1", TxEn);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] wq[$];
    int low;
    RST = 1'b1; WrEn = 1'b1; WrData = 8'h77; Flush = 1'b0; Doneflg = 1'b1;
    @(negedge CLK); @(negedge CLK);
    WrEn = 1'b0; Doneflg = 1'b0; RST = 1'b0;
    chk_en = 1'b1;
    chk("rst_txen", TxEn, 0);  chk("rst_empty", Empty, 1); chk("rst_full", Full, 0);
    chk("rst_count", Count, 0); chk("rst_busy", Busy, 0);  chk("rst_ovf", Overflow, 0);
    chk("rst_sd", Senddat, 8'h00);

    // Single byte, Doneflg ignored outside SEND
    cyc(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("a5_cnt1", Count, 1); chk("a5_tx_lo", TxEn, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("a5_busy_load", Busy, 1); chk("a5_tx_lo2", TxEn, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("a5_txen", TxEn, 1); chk("a5_sd", Senddat, 8'hA5); chk("a5_cnt0", Count, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("a5_hold", TxEn, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("a5_done_tx", TxEn, 0); chk("a5_gap_busy", Busy, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("a5_idle_busy", Busy, 0); chk("a5_empty", Empty, 1);

    // Burst 01..05
    sent.delete();
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i + 1), 1'b0, 1'b0);
    chk("burst_cnt4", Count, 4); chk("burst_tx", TxEn, 1);
    for (int f = 0; f < 5; f++) begin
      wait_tx(20);
      chk($sformatf("burst_sd%0d", f), Senddat, 32'(f + 1));
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      if (f < 4) begin
        low = 0;
        while (TxEn !== 1'b1 && low < 10) begin low++; cyc(1'b0, 8'h00, 1'b0, 1'b0); end
        chk($sformatf("burst_gap%0d", f), low, 2);
      end
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("burst_idle", Busy, 0); chk("burst_cnt0", Count, 0);
    chk("burst_nsent", sent.size(), 5);

    // Overflow with Doneflg held low
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    sent.delete();
    for (int i = 0; i < 18; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    chk("ovf_cnt16", Count, 16); chk("ovf_full", Full, 1); chk("ovf_flag", Overflow, 1);
    chk("ovf_tx", TxEn, 1); chk("ovf_sd", Senddat, 8'h10);
    for (int f = 0; f < 17; f++) begin
      wait_tx(20);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
    end
    repeat (4) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("ovf_nsent", sent.size(), 17);
    for (int k = 0; k < 17 && k < sent.size(); k++) chk($sformatf("ovf_order%0d", k), sent[k], 32'(8'h10 + k));
    chk("ovf_sticky", Overflow, 1);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_flush_clr", Overflow, 0);

    // Pointer wrap, 40 bytes interleaved with Doneflg
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    sent.delete(); wq.delete();
    for (int i = 0; i < 40; i++) begin
      wq.push_back(8'(i * 7 + 3));
      cyc(1'b1, 8'(i * 7 + 3), 1'b0, TxEn === 1'b1);
      cyc(1'b0, 8'h00, 1'b0, TxEn === 1'b1);
    end
    for (int n = 0; n < 200 && (Busy !== 1'b0 || Empty !== 1'b1); n++) cyc(1'b0, 8'h00, 1'b0, TxEn === 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0); cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("wrap_nsent", sent.size(), 40); chk("wrap_ovf", Overflow, 0);
    for (int k = 0; k < 40 && k < sent.size(); k++) chk($sformatf("wrap_order%0d", k), sent[k], wq[k]);

    // Flush during SEND with three bytes queued
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    sent.delete();
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    chk("fl_cnt3", Count, 3); chk("fl_tx", TxEn, 1);
    cyc(1'b1, 8'h99, 1'b1, 1'b0);
    chk("fl_cnt0", Count, 0); chk("fl_empty", Empty, 1); chk("fl_tx_kept", TxEn, 1);
    chk("fl_sd", Senddat, 8'h40); chk("fl_ovf", Overflow, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    chk("fl_done", TxEn, 0);
    repeat (8) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("fl_nsent", sent.size(), 1); chk("fl_idle", Busy, 0);

    // Flush in the same cycle as the LOAD pop
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    sent.delete();
    cyc(1'b1, 8'h61, 1'b0, 1'b0);
    cyc(1'b1, 8'h62, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    chk("lp_tx", TxEn, 1); chk("lp_sd", Senddat, 8'h61); chk("lp_cnt0", Count, 0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (5) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("lp_nsent", sent.size(), 1); chk("lp_busy", Busy, 0);

    // Reset mid-frame with five bytes queued
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    chk("rm_cnt5", Count, 5); chk("rm_tx", TxEn, 1);
    cyc(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1);
    chk("rm_tx0", TxEn, 0); chk("rm_cnt0", Count, 0); chk("rm_empty", Empty, 1);
    chk("rm_busy", Busy, 0); chk("rm_sd", Senddat, 8'h00);
    repeat (6) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rm_quiet", TxEn, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
